fsl_serial_bridge: RTL and testbench

//  Bidirectional FSL <-> RS-232 UART bridge (8N1, RTS/CTS flow control).
//  FSL slave bytes are serialized onto rs232_tx_data_o. Bytes received on
//  rs232_rx_data_i are pushed to the FSL master port. Byte payload is
//  FSL bits [24:31], where bit 31 is the LSB. Sits between a MicroBlaze FSL

---
 rtl/fsl_serial_bridge.sv | 243 ++++++++++++++++++++++++
 tb/tb_fsl_serial_bridge.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsl_serial_bridge.sv
// fsl_serial_bridge: bidirectional FSL <-> RS-232 8N1 bridge with RTS/CTS flow control.
// FSL bit 31 (IBM numbering, the byte LSB) appears as bit 0 of the [31:0] data ports here.
module fsl_serial_bridge #(
  parameter int CLOCK_FREQ_MHZ = 50,
  parameter int BAUD_RATE      = 115200
) (
  input  logic        clock,
  input  logic        reset,
  output logic        FSL_S_CLK,
  input  logic [31:0] FSL_S_DATA,
  input  logic        FSL_S_CONTROL,
  input  logic        FSL_S_EXISTS,
  output logic        FSL_S_READ,
  output logic        FSL_M_CLK,
  output logic [31:0] FSL_M_DATA,
  output logic        FSL_M_CONTROL,
  input  logic        FSL_M_FULL,
  output logic        FSL_M_WRITE,
  output logic        rs232_tx_data_o,
  input  logic        rs232_rx_data_i,
  input  logic        rs232_rts_i,
  output logic        rs232_cts_o
);

  localparam int DIV = (CLOCK_FREQ_MHZ * 1000000 + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_e;

  txState_e        txState_q, txState_d;
  logic [CW-1:0]   txCnt_q, txCnt_d;
  logic [2:0]      txBit_q, txBit_d;
  logic [7:0]      txShift_q, txShift_d;
  logic            txLine_q, txLine_d;
  logic            sRead_q, sRead_d;
  logic            txTick, txAccept, txLoad;

  rxState_e        rxState_q, rxState_d;
  logic [CW-1:0]   rxCnt_q, rxCnt_d;
  logic [2:0]      rxBit_q, rxBit_d;
  logic [7:0]      rxShift_q, rxShift_d;
  logic            rxSync1_q, rxSync2_q, rxPrev_q;
  logic            rxDone;

  logic [7:0]      hold_q, hold_d;
  logic            valid_q, valid_d;
  logic [7:0]      mData_q, mData_d;
  logic            mWrite_q, mWrite_d;
  logic            holdPop;

  logic            unused_inputs;
  assign unused_inputs = ^{FSL_S_CONTROL, FSL_S_DATA[31:8]};

  assign txTick   = (txCnt_q == BIT_LAST);
  assign txAccept = FSL_S_EXISTS && !rs232_rts_i;

  // The last stop-bit cycle doubles as the idle decision point so queued bytes go out with no gap.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txLine_d  = txLine_q;
    sRead_d   = 1'b0;
    txLoad    = 1'b0;
    case (txState_q)
      TX_IDLE: begin
        txCnt_d  = '0;
        txLine_d = 1'b1;
        txLoad   = txAccept;
      end
      TX_START: begin
        if (txTick) begin
          txCnt_d   = '0;
          txBit_d   = '0;
          txLine_d  = txShift_q[0];
          txState_d = TX_DATA;
        end else begin
          txCnt_d = txCnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (txTick) begin
          txCnt_d   = '0;
          txShift_d = {1'b0, txShift_q[7:1]};
          if (txBit_q == 3'd7) begin
            txState_d = TX_STOP;
            txLine_d  = 1'b1;
          end else begin
            txBit_d  = txBit_q + 3'd1;
            txLine_d = txShift_q[1];
          end
        end else begin
          txCnt_d = txCnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (txTick) begin
          txCnt_d   = '0;
          txState_d = TX_IDLE;
          txLoad    = txAccept;
        end else begin
          txCnt_d = txCnt_q + CW'(1);
        end
      end
      default: txState_d = TX_IDLE;
    endcase
    if (txLoad) begin
      txState_d = TX_START;
      txCnt_d   = '0;
      txShift_d = FSL_S_DATA[7:0];
      txLine_d  = 1'b0;
      sRead_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txLine_q  <= 1'b1;
      sRead_q   <= 1'b0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
      txLine_q  <= txLine_d;
      sRead_q   <= sRead_d;
    end
  end

  // Sampling starts half a bit after the detected falling edge so every sample lands mid-bit.
  always_comb begin
    rxState_d = rxState_q;
    rxCnt_d   = rxCnt_q;
    rxBit_d   = rxBit_q;
    rxShift_d = rxShift_q;
    rxDone    = 1'b0;
    case (rxState_q)
      RX_IDLE: begin
        rxCnt_d = '0;
        if (rxPrev_q && !rxSync2_q) rxState_d = RX_START;
      end
      RX_START: begin
        if (rxCnt_q == HALF_LAST) begin
          rxCnt_d   = '0;
          rxBit_d   = '0;
          rxState_d = rxSync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxShift_d = {rxSync2_q, rxShift_q[7:1]};
          if (rxBit_q == 3'd7) rxState_d = RX_STOP;
          else rxBit_d = rxBit_q + 3'd1;
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rxCnt_q == BIT_LAST) begin
          rxCnt_d   = '0;
          rxState_d = RX_IDLE;
          rxDone    = rxSync2_q;
        end else begin
          rxCnt_d = rxCnt_q + CW'(1);
        end
      end
      default: rxState_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
    end else begin
      rxSync1_q <= rs232_rx_data_i;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
    end
  end

  // A byte arriving while the holder is full is dropped unless the holder drains that same cycle.
  always_comb begin
    holdPop  = valid_q && !FSL_M_FULL;
    valid_d  = valid_q;
    hold_d   = hold_q;
    mData_d  = mData_q;
    mWrite_d = 1'b0;
    if (holdPop) begin
      valid_d  = 1'b0;
      mWrite_d = 1'b1;
      mData_d  = hold_q;
    end
    if (rxDone && (!valid_q || holdPop)) begin
      valid_d = 1'b1;
      hold_d  = rxShift_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q   <= '0;
      valid_q  <= 1'b0;
      mData_q  <= '0;
      mWrite_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      mData_q  <= mData_d;
      mWrite_q <= mWrite_d;
    end
  end

  assign FSL_S_CLK       = clock;
  assign FSL_M_CLK       = clock;
  assign FSL_S_READ      = sRead_q;
  assign FSL_M_DATA      = {24'h0, mData_q};
  assign FSL_M_CONTROL   = 1'b0;
  assign FSL_M_WRITE     = mWrite_q;
  assign rs232_tx_data_o = txLine_q;
  assign rs232_cts_o     = valid_q;

endmodule

// File: tb/tb_fsl_serial_bridge.sv
// tb_fsl_serial_bridge: scoreboard bench for the FSL <-> RS-232 bridge at the default 434 clocks/bit.
// A modelled slave FIFO feeds the TX side; a write logger records every FSL master push.
module tb_fsl_serial_bridge;

  localparam int DIV = 434;

  logic        clock;
  logic        reset;
  logic        FSL_S_CLK;
  logic [31:0] FSL_S_DATA;
  logic        FSL_S_CONTROL;
  logic        FSL_S_EXISTS;
  logic        FSL_S_READ;
  logic        FSL_M_CLK;
  logic [31:0] FSL_M_DATA;
  logic        FSL_M_CONTROL;
  logic        FSL_M_FULL;
  logic        FSL_M_WRITE;
  logic        rs232_tx_data_o;
  logic        rs232_rx_data_i;
  logic        rs232_rts_i;
  logic        rs232_cts_o;

  int compared   = 0;
  int mismatched = 0;
  int readCount  = 0;
  int writeCount = 0;

  logic [7:0]  sFifo[$];
  logic [7:0]  txExp[$];
  logic [7:0]  rxExp[$];
  logic [31:0] writeLog[$];

  fsl_serial_bridge dut (
    .clock           (clock),
    .reset           (reset),
    .FSL_S_CLK       (FSL_S_CLK),
    .FSL_S_DATA      (FSL_S_DATA),
    .FSL_S_CONTROL   (FSL_S_CONTROL),
    .FSL_S_EXISTS    (FSL_S_EXISTS),
    .FSL_S_READ      (FSL_S_READ),
    .FSL_M_CLK       (FSL_M_CLK),
    .FSL_M_DATA      (FSL_M_DATA),
    .FSL_M_CONTROL   (FSL_M_CONTROL),
    .FSL_M_FULL      (FSL_M_FULL),
    .FSL_M_WRITE     (FSL_M_WRITE),
    .rs232_tx_data_o (rs232_tx_data_o),
    .rs232_rx_data_i (rs232_rx_data_i),
    .rs232_rts_i     (rs232_rts_i),
    .rs232_cts_o     (rs232_cts_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave FIFO model: the upper data bits carry junk that the bridge must ignore.
  initial begin
    FSL_S_EXISTS = 1'b0;
    FSL_S_DATA   = '0;
    forever begin
      @(negedge clock);
      if (FSL_S_READ === 1'b1) begin
        readCount++;
        if (sFifo.size() > 0) void'(sFifo.pop_front());
      end
      FSL_S_EXISTS = (sFifo.size() > 0);
      FSL_S_DATA   = (sFifo.size() > 0) ? {24'h5A5A5A, sFifo[0]} : 32'h0;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (FSL_M_WRITE === 1'b1) begin
        writeCount++;
        writeLog.push_back(FSL_M_DATA);
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clock);
    $display("[TB] FAIL watchdog: cycles got >=95000 required <95000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Waits for a start bit, then records the first sample of each bit and whether it held for DIV cycles.
  task automatic captureFrame(input int bound, output logic [9:0] bits, output bit stable,
                              output bit timedOut, output bit readAtStart, output int waited);
    waited      = 0;
    timedOut    = 1'b1;
    stable      = 1'b1;
    bits        = '1;
    readAtStart = 1'b0;
    while (waited < bound) begin
      @(negedge clock);
      waited++;
      if (rs232_tx_data_o === 1'b0) begin
        timedOut = 1'b0;
        break;
      end
    end
    if (!timedOut) begin
      readAtStart = FSL_S_READ;
      for (int i = 0; i < 10; i++) begin
        for (int c = 0; c < DIV; c++) begin
          if (i != 0 || c != 0) @(negedge clock);
          if (c == 0) bits[i] = rs232_tx_data_o;
          else if (rs232_tx_data_o !== bits[i]) stable = 1'b0;
        end
      end
    end
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
    rs232_rx_data_i = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rs232_rx_data_i = b[i];
      tick(DIV);
    end
    rs232_rx_data_i = stopBit;
    tick(DIV);
    rs232_rx_data_i = 1'b1;
  endtask

  task automatic test_reset();
    bit badDuring = 1'b0;
    logic [35:0] snap = '0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!badDuring && (rs232_tx_data_o !== 1'b1 || rs232_cts_o !== 1'b0 || FSL_S_READ !== 1'b0 ||
                         FSL_M_WRITE !== 1'b0 || FSL_M_DATA !== 32'h0)) begin
        badDuring = 1'b1;
        snap = {rs232_tx_data_o, rs232_cts_o, FSL_S_READ, FSL_M_WRITE, FSL_M_DATA};
      end
    end
    compared++;
    if (badDuring) begin
      mismatched++;
      $display("[TB] FAIL reset_hold: {tx,cts,read,write,mdata} got %h expected %h", snap, {4'b1000, 32'h0});
    end
    reset = 1'b0;
    tick(5);
    compared++;
    if (rs232_tx_data_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_tx: got %b expected 1", rs232_tx_data_o);
    end
    compared++;
    if (rs232_cts_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_cts: got %b expected 0", rs232_cts_o);
    end
    compared++;
    if (FSL_S_READ !== 1'b0 || FSL_M_WRITE !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_strobes: read/write got %b%b expected 00", FSL_S_READ, FSL_M_WRITE);
    end
    compared++;
    if (FSL_M_DATA !== 32'h0 || FSL_M_CONTROL !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mdata: data/control got %h/%b expected 00000000/0", FSL_M_DATA, FSL_M_CONTROL);
    end
  endtask

  task automatic test_tx_frame();
    logic [9:0] bits, expFrame;
    logic [7:0] e;
    bit stable, timedOut, readAtStart;
    int waited;
    int r0 = readCount;
    sFifo.push_back(8'hA0);
    txExp.push_back(8'hA0);
    captureFrame(200, bits, stable, timedOut, readAtStart, waited);
    compared++;
    if (timedOut) begin
      mismatched++;
      $display("[TB] FAIL tx_start: start bit got none within 200 cycles expected one");
      return;
    end
    compared++;
    if (readAtStart !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL tx_read_align: READ in first start cycle got %b expected 1", readAtStart);
    end
    e = txExp.pop_front();
    expFrame = {1'b1, e, 1'b0};
    compared++;
    if (bits !== expFrame) begin
      mismatched++;
      $display("[TB] FAIL tx_bits: frame {stop,data,start} got %b expected %b", bits, expFrame);
    end
    compared++;
    if (!stable) begin
      mismatched++;
      $display("[TB] FAIL tx_bit_timing: every bit held %0d clocks got no expected yes", DIV);
    end
    tick(5);
    compared++;
    if (readCount - r0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL tx_read_count: got %0d expected 1", readCount - r0);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] bits, expFrame;
    logic [7:0] e;
    bit stable, timedOut, readAtStart;
    int waited;
    int r0 = readCount;
    for (int i = 0; i < 3; i++) begin
      sFifo.push_back(8'hA0 + 8'(i));
      txExp.push_back(8'hA0 + 8'(i));
    end
    for (int f = 0; f < 3; f++) begin
      captureFrame((f == 0) ? 200 : 2, bits, stable, timedOut, readAtStart, waited);
      compared++;
      if (timedOut) begin
        mismatched++;
        $display("[TB] FAIL b2b_start%0d: start bit got none expected one", f);
        break;
      end
      if (f > 0) begin
        compared++;
        if (waited !== 1) begin
          mismatched++;
          $display("[TB] FAIL b2b_gap%0d: idle cycles got %0d expected 0", f, waited - 1);
        end
      end
      e = txExp.pop_front();
      expFrame = {1'b1, e, 1'b0};
      compared++;
      if (bits !== expFrame || !stable || readAtStart !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL b2b_frame%0d: bits/stable/read got %b/%b/%b expected %b/1/1",
                 f, bits, stable, readAtStart, expFrame);
      end
    end
    tick(5);
    compared++;
    if (readCount - r0 !== 3) begin
      mismatched++;
      $display("[TB] FAIL b2b_read_count: got %0d expected 3", readCount - r0);
    end
  endtask

  task automatic test_rts_flow();
    logic [9:0] bits, expFrame;
    logic [7:0] e;
    bit stable, timedOut, readAtStart;
    int waited;
    bit seenLow = 1'b0;
    int r0;
    rs232_rts_i = 1'b1;
    r0 = readCount;
    sFifo.push_back(8'h55);
    txExp.push_back(8'h55);
    repeat (2 * DIV) begin
      @(negedge clock);
      if (rs232_tx_data_o !== 1'b1) seenLow = 1'b1;
    end
    compared++;
    if (seenLow || readCount !== r0) begin
      mismatched++;
      $display("[TB] FAIL rts_block: txLow/reads got %b/%0d expected 0/0", seenLow, readCount - r0);
    end
    rs232_rts_i = 1'b0;
    // Raising rts once the frame is under way must not cut it short.
    fork
      captureFrame(200, bits, stable, timedOut, readAtStart, waited);
      begin
        for (int k = 0; k < 200 && FSL_S_READ !== 1'b1; k++) @(negedge clock);
        tick(3 * DIV);
        rs232_rts_i = 1'b1;
      end
    join
    e = txExp.pop_front();
    expFrame = {1'b1, e, 1'b0};
    compared++;
    if (timedOut || bits !== expFrame || !stable) begin
      mismatched++;
      $display("[TB] FAIL rts_release_frame: timeout/bits/stable got %b/%b/%b expected 0/%b/1",
               timedOut, bits, stable, expFrame);
    end
    rs232_rts_i = 1'b0;
    tick(5);
    compared++;
    if (readCount - r0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL rts_read_count: got %0d expected 1", readCount - r0);
    end
  endtask

  task automatic test_rx_frame();
    logic [31:0] got;
    logic [7:0] e;
    int w0;
    writeLog.delete();
    rxExp.delete();
    w0 = writeCount;
    rxExp.push_back(8'hAB);
    sendRxFrame(8'hAB, 1'b1);
    tick(20);
    compared++;
    if (writeCount - w0 !== 1) begin
      mismatched++;
      $display("[TB] FAIL rx_write_count: got %0d expected 1", writeCount - w0);
    end
    compared++;
    if (writeLog.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL rx_data: write got none expected %h", {24'h0, rxExp[0]});
    end else begin
      got = writeLog.pop_front();
      e = rxExp.pop_front();
      if (got !== {24'h0, e}) begin
        mismatched++;
        $display("[TB] FAIL rx_data: got %h expected %h", got, {24'h0, e});
      end
    end
    compared++;
    if (FSL_M_DATA !== 32'h0000_00AB || rs232_cts_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rx_after_write: mdata/cts got %h/%b expected 000000ab/0", FSL_M_DATA, rs232_cts_o);
    end
  endtask

  task automatic test_rx_full();
    logic [31:0] got;
    logic [7:0] e;
    bit wrote = 1'b0;
    int w0;
    writeLog.delete();
    rxExp.delete();
    w0 = writeCount;
    FSL_M_FULL = 1'b1;
    rxExp.push_back(8'h3C);
    sendRxFrame(8'h3C, 1'b1);
    tick(20);
    compared++;
    if (rs232_cts_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL full_cts: got %b expected 1", rs232_cts_o);
    end
    repeat (200) begin
      @(negedge clock);
      if (FSL_M_WRITE !== 1'b0) wrote = 1'b1;
    end
    compared++;
    if (wrote || writeCount !== w0) begin
      mismatched++;
      $display("[TB] FAIL full_blocked: writes got %0d expected 0", writeCount - w0);
    end
    FSL_M_FULL = 1'b0;
    tick(5);
    compared++;
    if (writeCount - w0 !== 1 || writeLog.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL full_release_count: got %0d expected 1", writeCount - w0);
    end else begin
      got = writeLog.pop_front();
      e = rxExp.pop_front();
      compared++;
      if (got !== {24'h0, e}) begin
        mismatched++;
        $display("[TB] FAIL full_release_data: got %h expected %h", got, {24'h0, e});
      end
    end
    compared++;
    if (rs232_cts_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_cts_clear: got %b expected 0", rs232_cts_o);
    end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] got;
    logic [7:0] e;
    int w0;
    writeLog.delete();
    rxExp.delete();
    w0 = writeCount;
    FSL_M_FULL = 1'b1;
    rxExp.push_back(8'h11);
    sendRxFrame(8'h11, 1'b1);
    sendRxFrame(8'h22, 1'b1);
    tick(20);
    compared++;
    if (rs232_cts_o !== 1'b1 || writeCount !== w0) begin
      mismatched++;
      $display("[TB] FAIL overrun_hold: cts/writes got %b/%0d expected 1/0", rs232_cts_o, writeCount - w0);
    end
    FSL_M_FULL = 1'b0;
    tick(DIV);
    compared++;
    if (writeCount - w0 !== 1 || writeLog.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL overrun_count: got %0d expected 1", writeCount - w0);
    end else begin
      got = writeLog.pop_front();
      e = rxExp.pop_front();
      compared++;
      if (got !== {24'h0, e}) begin
        mismatched++;
        $display("[TB] FAIL overrun_data: got %h expected %h", got, {24'h0, e});
      end
    end
  endtask

  task automatic test_rx_errors();
    int w0;
    writeLog.delete();
    w0 = writeCount;
    rs232_rx_data_i = 1'b0;
    tick(100);
    rs232_rx_data_i = 1'b1;
    tick(11 * DIV);
    compared++;
    if (writeCount !== w0 || rs232_cts_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL glitch_reject: writes/cts got %0d/%b expected 0/0", writeCount - w0, rs232_cts_o);
    end
    sendRxFrame(8'h5A, 1'b0);
    tick(20);
    compared++;
    if (rs232_cts_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL framing_cts: got %b expected 0", rs232_cts_o);
    end
    compared++;
    if (writeCount !== w0) begin
      mismatched++;
      $display("[TB] FAIL framing_write: writes got %0d expected 0", writeCount - w0);
    end
  endtask

  task automatic test_midframe_reset();
    int k = 0;
    int w0, r0;
    bit seenLow = 1'b0;
    sFifo.push_back(8'h00);
    while (FSL_S_READ !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    compared++;
    if (k >= 200) begin
      mismatched++;
      $display("[TB] FAIL abort_start: READ got none within 200 cycles expected one");
    end
    rs232_rx_data_i = 1'b0;
    tick(3 * DIV);
    compared++;
    if (rs232_tx_data_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_midframe_tx: got %b expected 0", rs232_tx_data_o);
    end
    reset = 1'b1;
    @(negedge clock);
    compared++;
    if (rs232_tx_data_o !== 1'b1 || FSL_S_READ !== 1'b0 || FSL_M_WRITE !== 1'b0 || rs232_cts_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_outputs: tx/read/write/cts got %b%b%b%b expected 1000",
               rs232_tx_data_o, FSL_S_READ, FSL_M_WRITE, rs232_cts_o);
    end
    compared++;
    if (FSL_M_DATA !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL abort_mdata: got %h expected 00000000", FSL_M_DATA);
    end
    tick(1);
    reset = 1'b0;
    rs232_rx_data_i = 1'b1;
    w0 = writeCount;
    r0 = readCount;
    repeat (9 * DIV) begin
      @(negedge clock);
      if (rs232_tx_data_o !== 1'b1) seenLow = 1'b1;
    end
    compared++;
    if (seenLow || writeCount !== w0 || readCount !== r0) begin
      mismatched++;
      $display("[TB] FAIL abort_drop: txLow/writes/reads got %b/%0d/%0d expected 0/0/0",
               seenLow, writeCount - w0, readCount - r0);
    end
  endtask

  initial begin
    reset           = 1'b1;
    FSL_S_CONTROL   = 1'b1;
    FSL_M_FULL      = 1'b0;
    rs232_rx_data_i = 1'b1;
    rs232_rts_i     = 1'b0;
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_rts_flow();
    test_rx_frame();
    test_rx_full();
    test_rx_overrun();
    test_rx_errors();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
